// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the streaming pooling engine.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Accumulator must hold the full sum of WIN*WIN samples without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned win);
    return data_w + 2 * $clog2(win);
  endfunction

  function automatic bit win_is_legal(input int unsigned win);
    return (win == 2) || (win == 4) || (win == 8);
  endfunction

endpackage

// File: rtl/pool_reduce_step.sv
// Single-step window reducer: loads on the first sample, otherwise folds the
// sample into the accumulator by signed max or by addition.
module pool_reduce_step
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 36
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  pool_mode_e               mode_i,
  input  logic                     first_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W - DATA_W){sample_i[DATA_W-1]}}, sample_i};

  always_comb begin
    acc_o = sample_ext;
    if (!first_i) begin
      case (mode_i)
        POOL_MAX: acc_o = (sample_ext > acc_i) ? sample_ext : acc_i;
        POOL_AVG: acc_o = acc_i + sample_ext;
        default:  acc_o = sample_ext;
      endcase
    end
  end

endmodule

// File: rtl/stream_max_pool.sv
// Streaming WIN x WIN pooling engine (max or floor-average per window) with a
// single-entry output register and valid/ready handshakes on both sides.
module stream_max_pool
  import pool_pkg::*;
#(
  parameter int unsigned WIN    = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     win_busy
);

  localparam int unsigned WIN_SQ    = WIN * WIN;
  localparam int unsigned CNT_W     = $clog2(WIN_SQ);
  localparam int unsigned ACC_W     = acc_width(DATA_W, WIN);
  localparam int unsigned SHIFT     = 2 * $clog2(WIN);
  localparam bit          WIN_LEGAL = win_is_legal(WIN);

  if (!WIN_LEGAL) begin : g_bad_win
    $error("stream_max_pool: WIN must be 2, 4 or 8");
  end

  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  pool_mode_e               mode_q, mode_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  logic                     first_sample;
  logic                     last_sample;
  logic                     in_xfer;
  pool_mode_e               step_mode;
  logic signed [ACC_W-1:0]  step_acc;
  logic signed [ACC_W-1:0]  avg_full;
  logic signed [DATA_W-1:0] result;

  assign first_sample = (count_q == '0);
  assign last_sample  = (count_q == CNT_W'(WIN_SQ - 1));
  assign in_ready     = !out_valid_q || out_ready;
  assign in_xfer      = in_valid && in_ready;
  assign step_mode    = first_sample ? pool_mode_e'(mode) : mode_q;

  pool_reduce_step #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_step (
    .acc_i    (acc_q),
    .sample_i (in_data),
    .mode_i   (step_mode),
    .first_i  (first_sample),
    .acc_o    (step_acc)
  );

  // Arithmetic shift of the exact sum gives the floor-toward-minus-infinity mean.
  always_comb begin
    avg_full = step_acc >>> SHIFT;
    result   = (step_mode == POOL_AVG) ? avg_full[DATA_W-1:0] : step_acc[DATA_W-1:0];
  end

  always_comb begin
    count_d     = count_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A result load on the same edge as a drain wins, so there is no bubble.
    if (in_xfer) begin
      acc_d   = step_acc;
      count_d = last_sample ? '0 : count_q + CNT_W'(1);
      if (first_sample) begin
        mode_d = pool_mode_e'(mode);
      end
      if (last_sample) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      acc_q       <= '0;
      mode_q      <= POOL_MAX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_busy  = (count_q != '0);

endmodule

// File: tb/tb_stream_max_pool.sv
// Bench for stream_max_pool: directed WIN=2 scenarios plus a randomized WIN=4,
// DATA_W=16 stream checked against a window-level arithmetic model.
module tb_stream_max_pool;

  logic clk;
  logic rst_n;

  logic               a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_win_busy;
  logic signed [31:0] a_in_data, a_out_data;

  logic               b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_win_busy;
  logic signed [15:0] b_in_data, b_out_data;

  int check_count = 0;
  int pass_count  = 0;

  stream_max_pool #(.WIN(2), .DATA_W(32)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .mode      (a_mode),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .win_busy  (a_win_busy)
  );

  stream_max_pool #(.WIN(4), .DATA_W(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .mode      (b_mode),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .win_busy  (b_win_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: max of the window, or the exact mean rounded toward minus infinity.
  function automatic longint model_window(input longint s[$], input bit is_avg);
    longint best;
    longint sum;
    longint n;
    best = s[0];
    sum  = 0;
    n    = s.size();
    foreach (s[i]) begin
      if (s[i] > best) best = s[i];
      sum += s[i];
    end
    if (!is_avg) return best;
    if (sum >= 0) return sum / n;
    return -((-sum + n - 1) / n);
  endfunction

  task automatic a_push(input longint d, input logic m);
    int waited;
    waited = 0;
    a_in_data  = 32'(d);
    a_mode     = m;
    a_in_valid = 1'b1;
    while (!a_in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!a_in_ready) begin
      check_count++;
      $display("[TB] FAIL a_push_timeout: in_ready=%0b required=1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_window(input longint s[$], input logic m_first, input logic m_rest);
    foreach (s[i]) a_push(s[i], (i == 0) ? m_first : m_rest);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_mode = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_mode = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_count++;
    if (a_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got=%0b want=0", a_out_valid);
    else pass_count++;
    check_count++;
    if (a_out_data !== 32'sd0) $display("[TB] FAIL reset_out_data: got=%0d want=0", a_out_data);
    else pass_count++;
    check_count++;
    if (a_win_busy !== 1'b0) $display("[TB] FAIL reset_win_busy: got=%0b want=0", a_win_busy);
    else pass_count++;
    check_count++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got=%0b want=1", a_in_ready);
    else pass_count++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max_win2();
    longint s[$] = '{3, -7, 12, 5};
    longint exp;
    exp = model_window(s, 1'b0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) a_push(s[i], 1'b0);
    check_count++;
    if (a_out_valid !== 1'b0 || a_win_busy !== 1'b1)
      $display("[TB] FAIL max_partial: out_valid=%0b win_busy=%0b want 0/1", a_out_valid, a_win_busy);
    else pass_count++;
    a_push(s[3], 1'b0);
    check_count++;
    if (a_out_valid !== 1'b1) $display("[TB] FAIL max_latency: out_valid=%0b want=1", a_out_valid);
    else pass_count++;
    check_count++;
    if (longint'(a_out_data) !== exp) $display("[TB] FAIL max_result: got=%0d want=%0d", a_out_data, exp);
    else pass_count++;
  endtask

  task automatic test_avg_win2();
    longint s1[$] = '{3, -7, 12, 5};
    longint s2[$] = '{-5, -6, -7, -8};
    longint exp;
    a_window(s1, 1'b1, 1'b1);
    exp = model_window(s1, 1'b1);
    check_count++;
    if (a_out_valid !== 1'b1 || longint'(a_out_data) !== exp)
      $display("[TB] FAIL avg_pos: valid=%0b got=%0d want=%0d", a_out_valid, a_out_data, exp);
    else pass_count++;
    a_window(s2, 1'b1, 1'b1);
    exp = model_window(s2, 1'b1);
    check_count++;
    if (a_out_valid !== 1'b1 || longint'(a_out_data) !== exp)
      $display("[TB] FAIL avg_neg_floor: valid=%0b got=%0d want=%0d", a_out_valid, a_out_data, exp);
    else pass_count++;
  endtask

  task automatic test_mode_flip();
    longint s1[$] = '{1, 9, 2, 4};
    longint s2[$] = '{1, 2, 3, 4};
    longint exp;
    a_window(s1, 1'b0, 1'b1);
    exp = model_window(s1, 1'b0);
    check_count++;
    if (longint'(a_out_data) !== exp) $display("[TB] FAIL mode_flip_ignored: got=%0d want=%0d", a_out_data, exp);
    else pass_count++;
    a_window(s2, 1'b1, 1'b0);
    exp = model_window(s2, 1'b1);
    check_count++;
    if (longint'(a_out_data) !== exp) $display("[TB] FAIL mode_next_avg: got=%0d want=%0d", a_out_data, exp);
    else pass_count++;
  endtask

  task automatic test_backpressure();
    longint s1[$] = '{1, 2, 3, 4};
    longint s2[$] = '{100, 200, 50, 7};
    longint exp;
    a_out_ready = 1'b1;
    a_window(s1, 1'b0, 1'b0);
    a_out_ready = 1'b0;
    a_in_data  = 32'(s2[0]);
    a_mode     = 1'b0;
    a_in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_count++;
    if (a_in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got=%0b want=0", a_in_ready);
    else pass_count++;
    check_count++;
    if (a_win_busy !== 1'b0) $display("[TB] FAIL bp_no_consume: win_busy=%0b want=0", a_win_busy);
    else pass_count++;
    check_count++;
    if (a_out_valid !== 1'b1 || longint'(a_out_data) !== model_window(s1, 1'b0))
      $display("[TB] FAIL bp_hold: valid=%0b data=%0d want 1/%0d", a_out_valid, a_out_data, model_window(s1, 1'b0));
    else pass_count++;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check_count++;
    if (a_out_valid !== 1'b0) $display("[TB] FAIL bp_single_drain: out_valid=%0b want=0", a_out_valid);
    else pass_count++;
    check_count++;
    if (a_win_busy !== 1'b1) $display("[TB] FAIL bp_resume_consume: win_busy=%0b want=1", a_win_busy);
    else pass_count++;
    for (int i = 1; i < 4; i++) a_push(s2[i], 1'b1);
    exp = model_window(s2, 1'b0);
    check_count++;
    if (a_out_valid !== 1'b1 || longint'(a_out_data) !== exp)
      $display("[TB] FAIL bp_second_window: valid=%0b got=%0d want=%0d", a_out_valid, a_out_data, exp);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    longint s[$] = '{-4, 8, -1, 6, 10, 11, -20, 3};
    longint w1[$] = '{-4, 8, -1, 6};
    longint w2[$] = '{10, 11, -20, 3};
    bit ready_ok;
    ready_ok = 1'b1;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_data = 32'(s[i]);
      a_mode    = (i < 4) ? 1'b1 : 1'b0;
      if (a_in_ready !== 1'b1) ready_ok = 1'b0;
      @(posedge clk); #1;
      if (i == 3) begin
        check_count++;
        if (a_out_valid !== 1'b1 || longint'(a_out_data) !== model_window(w1, 1'b1))
          $display("[TB] FAIL b2b_first: valid=%0b got=%0d want=%0d", a_out_valid, a_out_data, model_window(w1, 1'b1));
        else pass_count++;
      end
      if (i == 4) begin
        check_count++;
        if (a_out_valid !== 1'b0) $display("[TB] FAIL b2b_drain: out_valid=%0b want=0", a_out_valid);
        else pass_count++;
      end
    end
    a_in_valid = 1'b0;
    check_count++;
    if (a_out_valid !== 1'b1 || longint'(a_out_data) !== model_window(w2, 1'b0))
      $display("[TB] FAIL b2b_second: valid=%0b got=%0d want=%0d", a_out_valid, a_out_data, model_window(w2, 1'b0));
    else pass_count++;
    check_count++;
    if (!ready_ok) $display("[TB] FAIL b2b_bubble: in_ready dropped=1 want=0");
    else pass_count++;
  endtask

  task automatic test_reset_mid_window();
    longint s[$] = '{10, 20, 30, 40};
    longint exp;
    a_out_ready = 1'b1;
    a_push(5, 1'b1);
    a_push(6, 1'b1);
    a_out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_count++;
    if (a_out_valid !== 1'b0 || a_win_busy !== 1'b0)
      $display("[TB] FAIL rst_mid_state: out_valid=%0b win_busy=%0b want 0/0", a_out_valid, a_win_busy);
    else pass_count++;
    check_count++;
    if (a_out_data !== 32'sd0) $display("[TB] FAIL rst_mid_data: got=%0d want=0", a_out_data);
    else pass_count++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_window(s, 1'b0, 1'b0);
    exp = model_window(s, 1'b0);
    check_count++;
    if (a_out_valid !== 1'b1 || longint'(a_out_data) !== exp)
      $display("[TB] FAIL rst_fresh_window: valid=%0b got=%0d want=%0d", a_out_valid, a_out_data, exp);
    else pass_count++;
  endtask

  task automatic test_random_win4();
    localparam int NWIN = 30;
    localparam int WSZ  = 16;
    longint samples[$];
    bit     wmode[$];
    longint exp_q[$];
    longint win_s[$];
    longint v;
    int idx, got, cycle, r;
    for (int w = 0; w < NWIN; w++) begin
      win_s.delete();
      for (int k = 0; k < WSZ; k++) begin
        r = int'($urandom_range(0, 99));
        if (w == 0)       v = -32768;
        else if (w == 1)  v = 32767;
        else if (w == 2)  v = (k % 3 == 0) ? 32767 : -32768;
        else if (r < 8)   v = -32768;
        else if (r < 16)  v = 32767;
        else              v = longint'($urandom_range(0, 65535)) - 32768;
        win_s.push_back(v);
        samples.push_back(v);
      end
      wmode.push_back((w < 3) ? 1'b1 : 1'($urandom));
      exp_q.push_back(model_window(win_s, wmode[w]));
    end
    idx = 0; got = 0; cycle = 0;
    while ((idx < NWIN * WSZ || got < NWIN) && cycle < 20000) begin
      @(negedge clk);
      b_out_ready = ($urandom_range(0, 9) < 7);
      if (idx < NWIN * WSZ && $urandom_range(0, 9) < 8) begin
        b_in_valid = 1'b1;
        b_in_data  = 16'(samples[idx]);
        b_mode     = (idx % WSZ == 0) ? wmode[idx / WSZ] : 1'($urandom);
      end else begin
        b_in_valid = 1'b0;
        b_mode     = 1'($urandom);
      end
      #1;
      if (b_in_valid && b_in_ready) idx++;
      if (b_out_valid && b_out_ready) begin
        check_count++;
        if (got >= NWIN) $display("[TB] FAIL rand_extra_result: got=%0d want=none", b_out_data);
        else if (longint'(b_out_data) !== exp_q[got])
          $display("[TB] FAIL rand_window_%0d: got=%0d want=%0d", got, b_out_data, exp_q[got]);
        else pass_count++;
        got++;
      end
      cycle++;
    end
    @(negedge clk);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    check_count++;
    if (got != NWIN || idx != NWIN * WSZ)
      $display("[TB] FAIL rand_completion: results=%0d samples=%0d want %0d/%0d", got, idx, NWIN, NWIN * WSZ);
    else pass_count++;
  endtask

  initial begin
    test_reset();
    test_max_win2();
    test_avg_win2();
    test_mode_flip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_window();
    test_random_win4();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
